// File: rtl/stash_scanner_pkg.sv
// Shared definitions for the Stash reader side: FSM encoding and pointer width.
package stash_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADV  = 2'd1,
        ST_CAP  = 2'd2
    } scan_state_t;

    // Slot index width; the Stash uses the same formula so widths cannot diverge.
    function automatic int ptr_bits(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/stash_scanner_lim_inc.sv
// Limited incrementer: wraps L-1 -> 0, passes the input through when ci is low.
module stash_scanner_lim_inc #(
    parameter int L = 5,
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic         ci,
    output logic [W-1:0] sum
);

    // Wrap at L-1; for L=1 the result stays 0.
    always_comb begin
        sum = a;
        if (ci) begin
            sum = (a == W'(L - 1)) ? '0 : a + W'(1);
        end
    end

endmodule

// File: rtl/stash_scanner.sv
// Reader-side controller for the Stash: pulses next_sample, latches the exposed
// sample for display, and browses slots manually or on a fixed scan period.
//
// state    | meaning
// ST_IDLE  | waiting for a manual or scan trigger
// ST_ADV   | next_sample high this cycle, display index advances
// ST_CAP   | Stash now exposes the new slot, capture it
module stash_scanner
    import stash_scanner_pkg::*;
#(
    parameter  int DEPTH    = 5,
    parameter  int PERIOD   = 100000000,
    localparam int PTR_BITS = ptr_bits(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scan_toggle,
    input  logic                manual_next,
    input  logic                new_sample,
    input  logic [7:0]          stash_sample,
    output logic                next_sample,
    output logic [7:0]          disp_sample,
    output logic [PTR_BITS-1:0] disp_index,
    output logic                scanning
);

    localparam int TICK_BITS = (PERIOD <= 1) ? 1 : $clog2(PERIOD);
    localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(PERIOD - 1);

    scan_state_t         state;
    scan_state_t         state_next;
    logic [PTR_BITS-1:0] wr_idx;
    logic [PTR_BITS-1:0] wr_idx_inc;
    logic [PTR_BITS-1:0] disp_index_inc;
    logic [TICK_BITS-1:0] tick;
    logic                trigger;
    logic                manual_taken;
    logic                disp_ci;
    logic                next_sample_d;

    assign trigger      = manual_next | (scanning & (tick == TICK_LAST));
    assign manual_taken = manual_next & (state == ST_IDLE) & ~new_sample;

    stash_scanner_lim_inc #(.L(DEPTH), .W(PTR_BITS)) u_disp_inc (
        .a   (disp_index),
        .ci  (disp_ci),
        .sum (disp_index_inc)
    );

    stash_scanner_lim_inc #(.L(DEPTH), .W(PTR_BITS)) u_wr_inc (
        .a   (wr_idx),
        .ci  (new_sample),
        .sum (wr_idx_inc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a writer store aborts any browse in flight.
    always_comb begin
        state_next = state;
        if (new_sample) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = trigger ? ST_ADV : ST_IDLE;
                ST_ADV:  state_next = ST_CAP;
                ST_CAP:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode: pulse request and the display-index advance enable.
    always_comb begin
        next_sample_d = (state_next == ST_ADV);
        disp_ci       = (state == ST_ADV) & ~new_sample;
    end

    // Datapath: pulse flop, display registers, write-pointer mirror, scan timebase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            next_sample <= 1'b0;
            disp_sample <= '0;
            disp_index  <= '0;
            wr_idx      <= '0;
            scanning    <= 1'b0;
            tick        <= '0;
        end else begin
            next_sample <= next_sample_d;
            wr_idx      <= wr_idx_inc;
            if (new_sample) begin
                disp_index  <= wr_idx;
                disp_sample <= stash_sample;
                scanning    <= 1'b0;
                tick        <= '0;
            end else begin
                disp_index <= disp_index_inc;
                if (state == ST_CAP) begin
                    disp_sample <= stash_sample;
                end
                if (scan_toggle) begin
                    scanning <= ~scanning;
                    tick     <= '0;
                end else if (manual_taken && scanning) begin
                    tick <= '0;
                end else if (scanning) begin
                    tick <= (tick == TICK_LAST) ? '0 : tick + TICK_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stash_scanner.sv
// Bench for stash_scanner with a Stash fixture and a transaction-level model.
module tb_stash_scanner;

    localparam int D = 5;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_toggle;
    logic       manual_next;
    logic       new_sample;
    logic [7:0] din;
    logic [7:0] stash_sample;
    logic       next_sample;
    logic [7:0] disp_sample;
    logic [2:0] disp_index;
    logic       scanning;

    int checks   = 0;
    int failures = 0;

    stash_scanner #(.DEPTH(D), .PERIOD(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .scan_toggle  (scan_toggle),
        .manual_next  (manual_next),
        .new_sample   (new_sample),
        .stash_sample (stash_sample),
        .next_sample  (next_sample),
        .disp_sample  (disp_sample),
        .disp_index   (disp_index),
        .scanning     (scanning)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Stash fixture: storage with a read pointer that follows writes and next_sample.
    logic [7:0] mem [D];
    int s_rd = 0;
    int s_wr = 0;

    always_comb stash_sample = new_sample ? din : mem[s_rd];

    initial begin
        for (int i = 0; i < D; i++) mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (!reset) begin
                s_rd <= 0;
                s_wr <= 0;
            end else if (new_sample) begin
                mem[s_wr] <= din;
                s_rd      <= s_wr;
                s_wr      <= (s_wr + 1) % D;
            end else if (next_sample) begin
                s_rd <= (s_rd + 1) % D;
            end
        end
    end

    // Model: a browse request is a 2-cycle transaction (request, then capture).
    int m_idx = 0, m_wr = 0, m_smp = 0, m_tick = 0, pending = 0;
    bit m_scan = 0, m_ns = 0;

    initial begin
        bit fire;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_idx = 0; m_wr = 0; m_smp = 0; m_tick = 0; pending = 0;
                m_scan = 0; m_ns = 0;
            end else if (new_sample) begin
                m_idx = m_wr;
                m_wr  = (m_wr + 1) % D;
                m_smp = int'(stash_sample);
                m_scan = 0; m_tick = 0; pending = 0; m_ns = 0;
            end else begin
                fire = (pending == 0) && (manual_next || (m_scan && m_tick == P - 1));
                if (pending == 2) begin
                    m_idx = (m_idx + 1) % D;
                    m_ns = 0;
                    pending = 1;
                end else if (pending == 1) begin
                    m_smp = int'(stash_sample);
                    pending = 0;
                end else if (fire) begin
                    m_ns = 1;
                    pending = 2;
                end
                if (scan_toggle) begin
                    m_scan = !m_scan;
                    m_tick = 0;
                end else if (fire && manual_next && m_scan) begin
                    m_tick = 0;
                end else if (m_scan) begin
                    m_tick = (m_tick + 1) % P;
                end
            end
        end
    end

    // Compare process, away from the active edge.
    bit chk_en = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("next_sample", int'(next_sample), int'(m_ns));
                check("disp_index",  int'(disp_index),  m_idx);
                check("disp_sample", int'(disp_sample), m_smp);
                check("scanning",    int'(scanning),    int'(m_scan));
                check("wr_idx",      int'(dut.wr_idx),  m_wr);
                check("tick",        int'(dut.tick),    m_tick);
            end
        end
    end

    // Pulse counter and scan-interval check.
    int cyc = 0, ns_cnt = 0, last_pulse = -1;
    bit scan_chk = 0;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (next_sample) begin
                ns_cnt++;
                if (scan_chk) begin
                    if (last_pulse >= 0) check("scan_interval", cyc - last_pulse, P);
                    last_pulse = cyc;
                end
            end
            if (!scan_chk) last_pulse = -1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic write_sample(input logic [7:0] v);
        new_sample = 1'b1;
        din = v;
        @(negedge clk);
        new_sample = 1'b0;
    endtask

    task automatic manual_step();
        manual_next = 1'b1;
        @(negedge clk);
        manual_next = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int base;
        reset = 1'b0; scan_toggle = 1'b0; manual_next = 1'b0; new_sample = 1'b0; din = 8'h00;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst_index", int'(disp_index), 0);
        check("rst_sample", int'(disp_sample), 0);
        reset = 1'b1;
        @(negedge clk);

        // Five writes, then a manual advance that wraps 4 -> 0.
        for (int i = 1; i <= 5; i++) write_sample(8'(i * 8'h11));
        check("fill_index", int'(disp_index), 4);
        check("fill_sample", int'(disp_sample), 8'h55);
        base = ns_cnt;
        manual_next = 1'b1;
        @(negedge clk);
        manual_next = 1'b0;
        check("man_ns_high", int'(next_sample), 1);
        check("man_idx_hold", int'(disp_index), 4);
        @(negedge clk);
        check("man_ns_low", int'(next_sample), 0);
        check("man_idx_wrap", int'(disp_index), 0);
        @(negedge clk);
        check("man_sample", int'(disp_sample), 8'h11);
        check("man_pulses", ns_cnt - base, 1);

        // Triggers during ADV and CAP are dropped.
        base = ns_cnt;
        manual_next = 1'b1;
        repeat (3) @(negedge clk);
        manual_next = 1'b0;
        repeat (2) @(negedge clk);
        check("drop_pulses", ns_cnt - base, 1);
        check("drop_index", int'(disp_index), 1);

        // Reset in the ADV cycle.
        manual_next = 1'b1;
        @(negedge clk);
        manual_next = 1'b0;
        check("pre_rst_ns", int'(next_sample), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_ns", int'(next_sample), 0);
        check("midrst_index", int'(disp_index), 0);
        check("midrst_sample", int'(disp_sample), 0);
        base = ns_cnt;
        repeat (3) @(negedge clk);
        check("midrst_no_pulse", ns_cnt - base, 0);

        // Automatic scan with PERIOD=4.
        for (int i = 1; i <= 5; i++) write_sample(8'hA0 + 8'(i));
        base = ns_cnt;
        scan_toggle = 1'b1;
        scan_chk = 1;
        @(negedge clk);
        scan_toggle = 1'b0;
        repeat (19) @(negedge clk);
        check("scan_pulses", ns_cnt - base, 4);
        check("scan_index", int'(disp_index), 3);
        scan_toggle = 1'b1;
        @(negedge clk);
        scan_toggle = 1'b0;
        scan_chk = 0;
        repeat (4) @(negedge clk);

        // new_sample in the ADV cycle of a scan advance.
        reset_pulse();
        write_sample(8'h01);
        write_sample(8'h02);
        for (int i = 0; i < 4; i++) manual_step();
        check("setup_index", int'(disp_index), 0);
        scan_toggle = 1'b1;
        @(negedge clk);
        scan_toggle = 1'b0;
        for (int k = 0; k < 20 && !next_sample; k++) @(negedge clk);
        check("wait_adv", int'(next_sample), 1);
        write_sample(8'h9A);
        check("ns_adv_index", int'(disp_index), 2);
        check("ns_adv_sample", int'(disp_sample), 8'h9A);
        check("ns_adv_scan", int'(scanning), 0);
        check("ns_adv_wr", int'(dut.wr_idx), 3);
        repeat (3) @(negedge clk);

        // Two toggles two cycles apart leave scanning off with no advance.
        base = ns_cnt;
        scan_toggle = 1'b1;
        @(negedge clk);
        scan_toggle = 1'b0;
        @(negedge clk);
        scan_toggle = 1'b1;
        @(negedge clk);
        scan_toggle = 1'b0;
        repeat (6) @(negedge clk);
        check("tog_scan", int'(scanning), 0);
        check("tog_tick", int'(dut.tick), 0);
        check("tog_pulses", ns_cnt - base, 0);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
